// File: rtl/aes_request_controller.sv
// -----------------------------------------------------------------------------
// aes_request_controller
//
// Core-clock stage sitting between spi_interface (sclk domain) and the AES
// core. A request frame from the SPI side either loads the key register or
// launches one AES operation on a 128-bit block. The core result is captured
// and held on valid_AES_out/data_AES_out/encrypt_out until the SPI side
// reports it as shifted out (sent), or until a new request arrives: a
// full-duplex frame returns the previous result while carrying the next one.
//
// valid_AES_in and sent are asynchronous to clk. Each goes through a
// SYNC_STAGES-deep synchronizer plus a history flop, giving a one-cycle
// rising-edge pulse in the clk domain. data_AES_in/encrypt_in/is_key are
// held stable by the SPI side while valid_AES_in is high, so they are
// sampled directly on the request pulse cycle.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   valid_AES_in        request frame valid (async level)
//   data_AES_in         128-bit frame payload (key or block)
//   encrypt_in          1 = encrypt, 0 = decrypt
//   is_key              1 = frame carries a key
//   sent                response shifted out (async level)
//   aes_key/aes_key_load   key register and one-cycle load strobe to core
//   aes_block/aes_encrypt  block and mode to core
//   aes_start           one-cycle start strobe to core
//   aes_done/aes_result one-cycle completion strobe and result from core
//   valid_AES_out/data_AES_out/encrypt_out   response back to spi_interface
//   clear_err           clears the sticky error flags
//   err_nokey           data request arrived with no key loaded
//   err_overrun         request dropped because an operation was in flight
//   err_timeout         core did not report done within TIMEOUT_CYCLES
//   busy                high while an operation is in START or BUSY
// -----------------------------------------------------------------------------
module aes_request_controller #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_AES_in,
  input  logic [127:0] data_AES_in,
  input  logic         encrypt_in,
  input  logic         is_key,
  input  logic         sent,
  output logic [127:0] aes_key,
  output logic         aes_key_load,
  output logic [127:0] aes_block,
  output logic         aes_encrypt,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_result,
  output logic         valid_AES_out,
  output logic [127:0] data_AES_out,
  output logic         encrypt_out,
  input  logic         clear_err,
  output logic         err_nokey,
  output logic         err_overrun,
  output logic         err_timeout,
  output logic         busy
);

  // Timer is one bit wider than needed so TIMEOUT_CYCLES-1 always fits.
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_BUSY   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer registers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_valid_sync;
  logic                   r_valid_hist;
  logic [SYNC_STAGES-1:0] r_sent_sync;
  logic                   r_sent_hist;
  logic                   w_req_pulse;
  logic                   w_sent_pulse;

  // ---------------------------------------------------------------------------
  // State and datapath registers, with their next-state wires
  // ---------------------------------------------------------------------------
  state_t          r_state,       w_state_nxt;
  logic [127:0]    r_key,         w_key_nxt;
  logic            r_key_valid,   w_key_valid_nxt;
  logic            r_key_load,    w_key_load_nxt;
  logic [127:0]    r_block,       w_block_nxt;
  logic            r_encrypt,     w_encrypt_nxt;
  logic            r_start,       w_start_nxt;
  logic [TW-1:0]   r_timer,       w_timer_nxt;
  logic [127:0]    r_data_out,    w_data_out_nxt;
  logic            r_enc_out,     w_enc_out_nxt;
  logic            r_valid_out,   w_valid_out_nxt;
  logic            r_err_nokey,   w_err_nokey_nxt;
  logic            r_err_overrun, w_err_overrun_nxt;
  logic            r_err_timeout, w_err_timeout_nxt;
  logic            r_busy,        w_busy_nxt;

  logic            w_set_nokey;
  logic            w_set_overrun;
  logic            w_set_timeout;
  logic            w_handle_req;

  // Synchronize valid_AES_in and sent into clk and keep one history flop each.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_sync <= {SYNC_STAGES{1'b0}};
      r_valid_hist <= 1'b0;
      r_sent_sync  <= {SYNC_STAGES{1'b0}};
      r_sent_hist  <= 1'b0;
    end else begin
      r_valid_sync <= {r_valid_sync[SYNC_STAGES-2:0], valid_AES_in};
      r_valid_hist <= r_valid_sync[SYNC_STAGES-1];
      r_sent_sync  <= {r_sent_sync[SYNC_STAGES-2:0], sent};
      r_sent_hist  <= r_sent_sync[SYNC_STAGES-1];
    end
  end

  // Rising-edge detect on the synchronized levels.
  assign w_req_pulse  = r_valid_sync[SYNC_STAGES-1] & ~r_valid_hist;
  assign w_sent_pulse = r_sent_sync[SYNC_STAGES-1]  & ~r_sent_hist;

  // Next-state and next-register computation for the request FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_key_nxt       = r_key;
    w_key_valid_nxt = r_key_valid;
    w_key_load_nxt  = 1'b0;
    w_block_nxt     = r_block;
    w_encrypt_nxt   = r_encrypt;
    w_start_nxt     = 1'b0;
    w_timer_nxt     = r_timer;
    w_data_out_nxt  = r_data_out;
    w_enc_out_nxt   = r_enc_out;
    w_valid_out_nxt = r_valid_out;
    w_set_nokey     = 1'b0;
    w_set_overrun   = 1'b0;
    w_set_timeout   = 1'b0;
    w_handle_req    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_handle_req = w_req_pulse;
      end
      ST_START: begin
        w_timer_nxt   = {TW{1'b0}};
        w_state_nxt   = ST_BUSY;
        w_set_overrun = w_req_pulse;
      end
      ST_BUSY: begin
        w_set_overrun = w_req_pulse;
        if (aes_done) begin
          w_data_out_nxt  = aes_result;
          w_enc_out_nxt   = r_encrypt;
          w_valid_out_nxt = 1'b1;
          w_state_nxt     = ST_RESULT;
        end else if (r_timer == TIMER_LAST) begin
          w_set_timeout = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      ST_RESULT: begin
        // A new request implies its full-duplex frame already carried the
        // held result back, so it retires the result just like sent does.
        if (w_req_pulse || w_sent_pulse) begin
          w_valid_out_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_valid_out_nxt = r_valid_out;
        end
        w_handle_req = w_req_pulse;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_valid_out_nxt = 1'b0;
      end
    endcase

    // Request handling shared by IDLE and the RESULT turnaround.
    if (w_handle_req) begin
      if (is_key) begin
        w_key_nxt       = data_AES_in;
        w_key_valid_nxt = 1'b1;
        w_key_load_nxt  = 1'b1;
        w_state_nxt     = ST_IDLE;
      end else if (!r_key_valid) begin
        w_set_nokey = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_block_nxt   = data_AES_in;
        w_encrypt_nxt = encrypt_in;
        w_start_nxt   = 1'b1;
        w_state_nxt   = ST_START;
      end
    end else begin
      w_key_load_nxt = 1'b0;
    end

    // Sticky flags: a set event in the same cycle as clear_err wins.
    w_err_nokey_nxt   = w_set_nokey   | (r_err_nokey   & ~clear_err);
    w_err_overrun_nxt = w_set_overrun | (r_err_overrun & ~clear_err);
    w_err_timeout_nxt = w_set_timeout | (r_err_timeout & ~clear_err);

    w_busy_nxt = (w_state_nxt == ST_START) || (w_state_nxt == ST_BUSY);
  end

  // State and datapath register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_key         <= 128'd0;
      r_key_valid   <= 1'b0;
      r_key_load    <= 1'b0;
      r_block       <= 128'd0;
      r_encrypt     <= 1'b0;
      r_start       <= 1'b0;
      r_timer       <= {TW{1'b0}};
      r_data_out    <= 128'd0;
      r_enc_out     <= 1'b0;
      r_valid_out   <= 1'b0;
      r_err_nokey   <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_key         <= w_key_nxt;
      r_key_valid   <= w_key_valid_nxt;
      r_key_load    <= w_key_load_nxt;
      r_block       <= w_block_nxt;
      r_encrypt     <= w_encrypt_nxt;
      r_start       <= w_start_nxt;
      r_timer       <= w_timer_nxt;
      r_data_out    <= w_data_out_nxt;
      r_enc_out     <= w_enc_out_nxt;
      r_valid_out   <= w_valid_out_nxt;
      r_err_nokey   <= w_err_nokey_nxt;
      r_err_overrun <= w_err_overrun_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign aes_key       = r_key;
  assign aes_key_load  = r_key_load;
  assign aes_block     = r_block;
  assign aes_encrypt   = r_encrypt;
  assign aes_start     = r_start;
  assign valid_AES_out = r_valid_out;
  assign data_AES_out  = r_data_out;
  assign encrypt_out   = r_enc_out;
  assign err_nokey     = r_err_nokey;
  assign err_overrun   = r_err_overrun;
  assign err_timeout   = r_err_timeout;
  assign busy          = r_busy;

endmodule
